// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arb_n registered, flow-controlled multiplexer:
// mode encodings, output-register state type and a select-width helper.
package mux_arb_pkg;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Select width that never collapses to zero bits for tiny channel counts.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: returns the first valid channel at or
// above ptr, wrapping modulo N_IN, as both a one-hot grant and an index.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = sel_width(N_IN)
) (
    input  logic [N_IN-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] idx
);

    logic found;
    int   cand;

    // Walk the channels in priority order starting at ptr and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_IN; off++) begin
            cand = (int'(ptr) + off) % N_IN;
            for (int i = 0; i < N_IN; i++) begin
                if (i == cand && !found && valid[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input registered multiplexer with valid/ready on every input and
// on the output. Selects a channel by explicit sel (fixed mode) or round-robin,
// and captures the beat into a single-entry output register.
// Optional feature macro: MUX_ARB_LOCK_EN (packet lock keyed on in_last).
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    out_state_t       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [N_IN-1:0]  rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic [N_IN-1:0]  gnt_vec;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_last;
    logic             gnt_any;
    logic             load_en;
    logic             xfer;

`ifdef MUX_ARB_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
`else
    // in_last only matters for packet lock; fold it away explicitly.
    logic             unused_last;
    assign unused_last = ^in_last ^ gnt_last;
`endif

    mux_arb_rr_pick #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // The register can take a new beat when empty or when its beat leaves this cycle.
    assign load_en = (state == ST_EMPTY) || out_ready;

    // Arbitration: lock (if enabled) overrides mode; otherwise fixed sel or round-robin.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
`ifdef MUX_ARB_LOCK_EN
        if (locked) begin
            gnt_idx = lock_ch;
            for (int i = 0; i < N_IN; i++) begin
                if (SEL_W'(i) == lock_ch) gnt_vec[i] = in_valid[i];
            end
        end else
`endif
        if (mode == MODE_RR) begin
            gnt_vec = rr_grant;
            gnt_idx = rr_idx;
        end else begin
            // An out-of-range sel matches no channel and therefore grants nothing.
            gnt_idx = sel;
            for (int i = 0; i < N_IN; i++) begin
                if (SEL_W'(i) == sel) gnt_vec[i] = in_valid[i];
            end
        end
    end

    // Steer the granted channel's payload toward the output register.
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt_vec[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_last = in_last[i];
            end
        end
    end

    assign gnt_any   = |gnt_vec;
    assign xfer      = gnt_any && load_en;
    // Ready is suppressed while reset is held so no producer sees a handshake.
    assign in_ready  = (load_en && rst_n) ? gnt_vec : '0;
    assign out_valid = (state == ST_FULL);

    // Output register and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            // NOTE: out_data is an ordinary pipeline register, not a memory array, so it is cheap and deterministic to reset.
            out_data <= '0;
            out_sel  <= '0;
            rr_ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (xfer) begin
                state    <= ST_FULL;
                out_data <= gnt_data;
                out_sel  <= gnt_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= SEL_W'((int'(gnt_idx) + 1) % N_IN);
                end
            end else if (state == ST_FULL && out_ready) begin
                state <= ST_EMPTY;
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: hold the grant on a channel until its last beat is transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            locked  <= !gnt_last;
            lock_ch <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (N_IN=4, WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_arb_n;

    localparam int N_IN  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk;
    logic                  rst_n;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_last;
    logic [N_IN-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    int errors = 0;
    int checks = 0;

    mux_arb_n #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'hF;
        in_last   = 4'h0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        in_valid = 4'h0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'hF;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready_empty: got %b want 0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid[%0d]: got %0b want 1", k, out_valid); end
            checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL fixed_data[%0d]: got %h want 33", k, out_data); end
            checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL fixed_sel[%0d]: got %0d want 2", k, out_sel); end
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready[%0d]: got %b want 0100", k, in_ready); end
        end
    endtask

    task automatic test_rr_all();
        logic [1:0] exp_sel [5];
        logic [7:0] exp_dat [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (out_sel !== exp_sel[k]) begin errors++; $display("FAIL rr_all_sel[%0d]: got %0d want %0d", k, out_sel, exp_sel[k]); end
            checks++; if (out_data !== exp_dat[k]) begin errors++; $display("FAIL rr_all_data[%0d]: got %h want %h", k, out_data, exp_dat[k]); end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_sel [3];
        exp_sel  = '{2'd1, 2'd3, 2'd1};
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_sparse_valid[%0d]: got %0b want 1", k, out_valid); end
            checks++; if (out_sel !== exp_sel[k]) begin errors++; $display("FAIL rr_sparse_sel[%0d]: got %0d want %0d", k, out_sel, exp_sel[k]); end
        end
    endtask

    task automatic test_backpressure();
        in_valid  = 4'hF;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_hold: got %b want 0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL bp_data[%0d]: got %h want 22", k, out_data); end
            checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d]: got %0d want 1", k, out_sel); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", k, out_valid); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        step();
        checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL bp_release_data: got %h want 33", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL bp_release_sel: got %0d want 2", out_sel); end
    endtask

    task automatic test_fixed_novalid();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1011;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL novalid_ready: got %b want 0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL novalid_drain: got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL novalid_data_hold: got %h want 33", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL novalid_sel_hold: got %0d want 2", out_sel); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL novalid_stay_empty: got %0b want 0", out_valid); end
    endtask

    // Highest sel index, then confirm the fixed-mode transfer left rr_ptr at 3.
    task automatic test_fixed_top_sel();
        sel      = 2'd3;
        in_valid = 4'hF;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL topsel_ready: got %b want 1000", in_ready); end
        step();
        checks++; if (out_data !== 8'h44) begin errors++; $display("FAIL topsel_data: got %h want 44", out_data); end
        checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL topsel_sel: got %0d want 3", out_sel); end
        mode = 1'b1;
        step();
        checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL topsel_ptr_kept: got %0d want 3", out_sel); end
    endtask

    task automatic test_reset_midxfer();
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", out_data); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b want 0000", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'h0;
        @(negedge clk);
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_sel [4];
        exp_sel  = '{2'd0, 2'd0, 2'd0, 2'd1};
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        step();
        checks++; if (out_sel !== exp_sel[0]) begin errors++; $display("FAIL lock_sel[0]: got %0d want 0", out_sel); end
        in_valid = 4'b0010;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL lock_block_other: got %b want 0000", in_ready); end
        in_valid = 4'b0011;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_ready_owner: got %b want 0001", in_ready); end
        step();
        checks++; if (out_sel !== exp_sel[1]) begin errors++; $display("FAIL lock_sel[1]: got %0d want 0", out_sel); end
        in_last = 4'b0001;
        step();
        checks++; if (out_sel !== exp_sel[2]) begin errors++; $display("FAIL lock_sel[2]: got %0d want 0", out_sel); end
        in_last = 4'b0000;
        step();
        checks++; if (out_sel !== exp_sel[3]) begin errors++; $display("FAIL lock_sel[3]: got %0d want 1", out_sel); end
        // ch1 is now mid-packet; reset must drop the beat and the lock.
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_rst_valid: got %0b want 0", out_valid); end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0001;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_cleared_ready: got %b want 0001", in_ready); end
        step();
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL lock_cleared_sel: got %0d want 0", out_sel); end
    endtask
`else
    task automatic test_last_ignored();
        logic [1:0] exp_sel [3];
        exp_sel  = '{2'd0, 2'd1, 2'd0};
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_sel !== exp_sel[k]) begin errors++; $display("FAIL nolock_sel[%0d]: got %0d want %0d", k, out_sel, exp_sel[k]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_fixed_novalid();
        test_fixed_top_sel();
        test_reset_midxfer();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`else
        test_last_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects a source channel either by an explicit `sel` (fixed mode) or by round-robin arbitration over valid inputs. The selected beat is captured into a single-entry output register. It is the sequential, flow-controlled successor to the combinational 4:1 mux and sits between multiple producer streams and one consumer.

## Interface
- `N_IN`, 4: number of input channels, 2..16.
- `WIDTH`, 8: data width per channel, ≥1.
- `SEL_W`, `$clog2(N_IN)`: select width (derived, not overridden).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in N_IN: per-channel valid.
- `in_data` in N_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_last` in N_IN: per-channel end-of-packet; used only with `MUX_ARB_LOCK_EN`.
- `in_ready` out N_IN: per-channel ready, at most one bit high.
- `mode` in 1: 0 = fixed (use `sel`), 1 = round-robin.
- `sel` in SEL_W: channel index in fixed mode.
- `out_valid` out 1: output register holds a beat.
- `out_data` out WIDTH: registered data.
- `out_sel` out SEL_W: channel the current beat came from.
- `out_ready` in 1: consumer accepts the beat.

## Operation
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = EMPTY, or (FULL and `out_ready`). This gives a full-throughput pass-through on simultaneous drain and fill.
- Fixed mode: grant channel `sel` if `in_valid[sel]`. If `sel` ≥ N_IN, there is no grant.
- Round-robin mode: grant the first valid channel searching upward from `rr_ptr`, wrapping modulo N_IN.
- `in_ready[g]` = `load_en` for the granted channel g. All other bits are 0. `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_ready` and state.
- Transfer on channel g (`in_valid[g] && in_ready[g]`):
  - `out_data` ← channel g data; `out_sel` ← g; state → FULL.
  - In round-robin mode, `rr_ptr` ← (g+1) mod N_IN. In fixed mode, `rr_ptr` is unchanged.
- FULL, `out_ready`, no grant: state → EMPTY. `out_data` and `out_sel` hold their last values.
- FULL, `out_ready`=0: `out_data`, `out_sel`, `out_valid` are stable. No input is accepted.
- A change of `mode` or `sel` takes effect at the next arbitration. A beat already in the register is never altered.

## Timing
- Reset (asynchronous assert, synchronous deassert by the surrounding design): `out_valid`=0, `out_data`=0, `out_sel`=0, `rr_ptr`=0, lock cleared.
- Latency is 1 cycle: an input accepted at edge k appears on the output after edge k.
- Sustained throughput is 1 beat/cycle while `out_ready`=1.
- Reset asserted mid-transfer discards the registered beat. No `in_ready` is high during reset.

## Configuration
- `MUX_ARB_LOCK_EN` defined: packet lock.
  - After a transfer from channel g with `in_last[g]`=0, the grant is locked to g until the beat with `in_last[g]`=1 is transferred.
  - The lock overrides `mode` and `sel`. While locked, other channels see `in_ready`=0 even when g is not valid.
- `MUX_ARB_LOCK_EN` undefined: `in_last` is ignored and arbitration runs on every beat.

## Structure
- Package `mux_arb_pkg` holds:
  - the `MODE_FIXED`/`MODE_RR` constants;
  - the EMPTY/FULL state typedef;
  - a `clog2`-safe select-width helper.
- Sub-module `mux_arb_rr_pick` is combinational. It takes the valid vector and pointer, and returns a one-hot grant and an index.

## Test plan
- Reset, then fixed mode, `sel`=2, all valid, `in_data`={0x44,0x33,0x22,0x11} (ch3..ch0), `out_ready`=1 → after one cycle `out_data`=0x33, `out_sel`=2, `in_ready`=0b0100 every cycle.
- Round-robin, all four valid and held, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0.
- Round-robin, only ch1 and ch3 valid → `out_sel` alternates 1,3,1. No bubbles.
- Backpressure: `out_ready`=0 for 3 cycles while FULL → `out_data` is stable and `in_ready`=0. On release, the next beat loads in the same cycle.
- Fixed mode, `sel`=2, `in_valid[2]`=0 → no transfer. `out_valid` drops after the pending beat drains.
- `MUX_ARB_LOCK_EN`: ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid → `out_sel` = 0,0,0,1. Reset asserted mid-packet → `out_valid`=0 and the lock is cleared.
